// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RISC-V load/store unit in front of a
// 64-bit synchronous data memory (read data arrives one cycle after the
// address). Sub-doubleword stores use a read-modify-write sequence.
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// H/W/D accesses complete immediately with Misaligned=1. When it is not
// defined, the offending low address bits are dropped instead.
module load_store_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        IsStore,
  input  logic [2:0]  Funct3,
  input  logic [63:0] Addr,
  input  logic [63:0] StoreData,
  output logic        Ready,
  output logic        Done,
  output logic [63:0] LoadData,
  output logic        Misaligned,
  output logic [63:0] MemRaddress,
  output logic [63:0] MemWaddress,
  output logic [63:0] MemDatain,
  input  logic [63:0] MemDataout,
  output logic        MemWr
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        isStore_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [2:0]  lane_q;
  logic [63:0] storeData_q;
  logic [63:0] addr_q;
  logic [63:0] datain_q;
  logic [63:0] loadData_q;

  logic        accept;
  logic [2:0]  alignMask;
  logic [2:0]  reqLane;
  logic        trapHit;
  logic [63:0] shifted;
  logic [63:0] extended;
  logic [7:0]  baseMask;
  logic [7:0]  byteMask;
  logic [63:0] laneMask;
  logic [63:0] merged;

  assign Ready       = (state_q == IDLE) && !Reset;
  assign accept      = Req && Ready;
  assign Done        = (state_q == DONE) && !Reset;
  assign MemWr       = (state_q == WR) && !Reset;
  assign MemRaddress = addr_q;
  assign MemWaddress = addr_q;
  assign MemDatain   = datain_q;
  assign LoadData    = loadData_q;

  // Low address bits that must be zero for the requested width (load 111 counts as D).
  always_comb begin
    case (Funct3[1:0])
      2'd0:    alignMask = 3'b000;
      2'd1:    alignMask = 3'b001;
      2'd2:    alignMask = 3'b011;
      default: alignMask = 3'b111;
    endcase
  end

  assign reqLane = Addr[2:0] & ~alignMask;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign trapHit    = |(Addr[2:0] & alignMask);
  assign Misaligned = misaligned_q;

  // Misalignment flag is captured at accept and held through the completion pulse.
  always_ff @(posedge Clk) begin
    if (Reset) misaligned_q <= 1'b0;
    else if (accept) misaligned_q <= trapHit;
  end
`else
  assign trapHit    = 1'b0;
  assign Misaligned = 1'b0;
`endif

  // Sequencing: loads RD->CAP->DONE, partial stores add WR, D stores skip the read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (trapHit) state_d = DONE;
          else if (IsStore && (Funct3[1:0] == 2'b11)) state_d = WR;
          else state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = isStore_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Right-justify the addressed lane of the read doubleword and extend it.
  always_comb begin
    shifted = MemDataout >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    extended = unsigned_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1:    extended = unsigned_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    extended = unsigned_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: extended = shifted;
    endcase
  end

  // Overlay the store bytes onto the read doubleword, keeping the other lanes.
  always_comb begin
    case (size_q)
      2'd0:    baseMask = 8'h01;
      2'd1:    baseMask = 8'h03;
      2'd2:    baseMask = 8'h0F;
      default: baseMask = 8'hFF;
    endcase
    byteMask = baseMask << lane_q;
    laneMask = '0;
    for (int i = 0; i < 8; i++) laneMask[i*8 +: 8] = {8{byteMask[i]}};
    merged = (MemDataout & ~laneMask) | ((storeData_q << {lane_q, 3'b000}) & laneMask);
  end

  // State register; a reset abandons whatever access is in flight.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Request capture at accept, then load result or merged write data in CAP.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      isStore_q   <= 1'b0;
      size_q      <= 2'd0;
      unsigned_q  <= 1'b0;
      lane_q      <= 3'd0;
      storeData_q <= '0;
      addr_q      <= '0;
      datain_q    <= '0;
      loadData_q  <= '0;
    end else if (accept) begin
      isStore_q   <= IsStore;
      size_q      <= Funct3[1:0];
      unsigned_q  <= !IsStore && Funct3[2];
      lane_q      <= reqLane;
      storeData_q <= StoreData;
      addr_q      <= {Addr[63:3], 3'b000};
      datain_q    <= StoreData;
      loadData_q  <= '0;
    end else if (state_q == CAP) begin
      if (isStore_q) datain_q <= merged;
      else loadData_q <= extended;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the documented examples followed by
// randomized traffic, all checked against a byte-level transaction model.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        IsStore;
  logic [2:0]  Funct3;
  logic [63:0] Addr;
  logic [63:0] StoreData;
  logic        Ready;
  logic        Done;
  logic [63:0] LoadData;
  logic        Misaligned;
  logic [63:0] MemRaddress;
  logic [63:0] MemWaddress;
  logic [63:0] MemDatain;
  logic [63:0] MemDataout;
  logic        MemWr;

  int checks = 0;
  int failures = 0;

  // Memory seen by the DUT and the model's own picture of it.
  logic [63:0] mem [0:31];
  logic [63:0] refMem [0:31];

  // Model state: one access in flight at most, cycles numbered per the interface.
  int          edgeCount = 0;
  int          busyEnd = 0;
  int          expDoneCyc = -1;
  int          expWrCyc = -1;
  logic [63:0] expLd = '0;
  logic        expMis = 1'b0;
  logic [63:0] expWrAddr = '0;
  logic [63:0] expWrData = '0;

  load_store_unit dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .IsStore(IsStore), .Funct3(Funct3),
    .Addr(Addr), .StoreData(StoreData), .Ready(Ready), .Done(Done),
    .LoadData(LoadData), .Misaligned(Misaligned), .MemRaddress(MemRaddress),
    .MemWaddress(MemWaddress), .MemDatain(MemDatain), .MemDataout(MemDataout),
    .MemWr(MemWr)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic bit trapEnabled();
`ifdef LSU_MISALIGN_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Access width in bytes from the RISC-V width code.
  function automatic int accessBytes(input logic st, input logic [2:0] f3);
    if (st) return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 8;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  // Gather size bytes little-endian from offset, then extend.
  function automatic logic [63:0] modelLoad(input logic [63:0] word, input int off, input int size, input bit sgn);
    logic [63:0] v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (sgn && size < 8 && v[8*size-1]) for (int i = 8*size; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] modelStore(input logic [63:0] word, input int off, input int size, input logic [63:0] sd);
    logic [63:0] w = word;
    for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = sd[8*i +: 8];
    return w;
  endfunction

  // Synchronous memory: read data one cycle after the address, write on MemWr.
  always @(posedge Clk) begin
    MemDataout <= mem[MemRaddress[7:3]];
    if (MemWr) mem[MemWaddress[7:3]] <= MemDatain;
  end

  // Transaction model: decides acceptance itself and schedules the expected events.
  always @(posedge Clk) begin
    int k, size, low, off;
    bit mis, trap, sgn;
    logic [63:0] word;
    edgeCount++;
    k = edgeCount;
    if (Reset) begin
      expDoneCyc = -1;
      expWrCyc = -1;
      busyEnd = k;
    end else begin
      if (expWrCyc == k) refMem[expWrAddr[7:3]] = expWrData;
      if (Req && k > busyEnd) begin
        size = accessBytes(IsStore, Funct3);
        low = int'(Addr[2:0]);
        mis = (low % size) != 0;
        trap = mis && trapEnabled();
        off = low - (low % size);
        sgn = !IsStore && !Funct3[2];
        word = refMem[Addr[7:3]];
        expWrCyc = -1;
        expLd = '0;
        expMis = trap;
        if (trap) begin
          expDoneCyc = k + 1;
        end else if (IsStore) begin
          expWrAddr = {Addr[63:3], 3'b000};
          expWrData = modelStore(word, off, size, StoreData);
          expWrCyc = (size == 8) ? k + 1 : k + 3;
          expDoneCyc = (size == 8) ? k + 2 : k + 4;
        end else begin
          expLd = modelLoad(word, off, size, sgn);
          expDoneCyc = k + 3;
        end
        busyEnd = expDoneCyc;
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge Clk) begin
    int cur;
    cur = edgeCount + 1;
    checkOutput("ready", {63'd0, Ready}, {63'd0, (!Reset && cur > busyEnd)});
    checkOutput("memwr", {63'd0, MemWr}, {63'd0, (!Reset && cur == expWrCyc)});
    if (!Reset) begin
      checkOutput("done", {63'd0, Done}, {63'd0, (cur == expDoneCyc)});
      if (cur == expDoneCyc) begin
        checkOutput("loaddata", LoadData, expLd);
        checkOutput("misaligned", {63'd0, Misaligned}, {63'd0, expMis});
      end
      if (cur == expWrCyc) begin
        checkOutput("memwaddress", MemWaddress, expWrAddr);
        checkOutput("memdatain", MemDatain, expWrData);
      end
    end
  end

  // Issue one request in an idle cycle and measure completion relative to the accept edge.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sd,
                               output int doneLat, output int wrLat, output int wrCount,
                               output logic [63:0] ld, output logic mis);
    Req = 1'b1; IsStore = st; Funct3 = f3; Addr = a; StoreData = sd;
    @(posedge Clk);
    #1 Req = 1'b0;
    doneLat = -1; wrLat = -1; wrCount = 0; ld = '0; mis = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge Clk);
      if (MemWr) begin
        wrCount++;
        if (wrLat < 0) wrLat = n;
      end
      if (Done) begin
        doneLat = n; ld = LoadData; mis = Misaligned;
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int dl, wl, wc;
    logic [63:0] ld;
    logic mis;
    bit sawDone;

    for (int i = 0; i < 32; i++) begin
      mem[i] = {$urandom, $urandom};
      refMem[i] = mem[i];
    end
    mem[2] = 64'h8877665544332211;
    refMem[2] = 64'h8877665544332211;

    Reset = 1'b1; Req = 1'b0; IsStore = 1'b0; Funct3 = 3'd0; Addr = '0; StoreData = '0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset_loaddata", LoadData, 64'd0);
    checkOutput("reset_done", {63'd0, Done}, 64'd0);
    checkOutput("reset_ready", {63'd0, Ready}, 64'd0);
    Reset = 1'b0;

    // Literal pins on the model itself.
    checkOutput("model_lb", modelLoad(64'h8877665544332211, 7, 1, 1'b1), 64'hFFFFFFFFFFFFFF88);
    checkOutput("model_sh", modelStore(64'h8877665544332211, 2, 2, 64'hABCD), 64'h88776655ABCD2211);

    applyStimulus(1'b0, 3'b000, 64'h17, '0, dl, wl, wc, ld, mis);
    checkOutput("lb_data", ld, 64'hFFFFFFFFFFFFFF88);
    checkOutput("lb_latency", 64'(dl), 64'd3);
    applyStimulus(1'b0, 3'b100, 64'h17, '0, dl, wl, wc, ld, mis);
    checkOutput("lbu_data", ld, 64'h0000000000000088);
    applyStimulus(1'b0, 3'b010, 64'h14, '0, dl, wl, wc, ld, mis);
    checkOutput("lw_data", ld, 64'hFFFFFFFF88776655);
    applyStimulus(1'b0, 3'b110, 64'h14, '0, dl, wl, wc, ld, mis);
    checkOutput("lwu_data", ld, 64'h0000000088776655);
    applyStimulus(1'b0, 3'b111, 64'h10, '0, dl, wl, wc, ld, mis);
    checkOutput("l111_data", ld, 64'h8877665544332211);

    applyStimulus(1'b1, 3'b001, 64'h12, 64'h000000000000ABCD, dl, wl, wc, ld, mis);
    checkOutput("sh_wr_cycle", 64'(wl), 64'd3);
    checkOutput("sh_wr_count", 64'(wc), 64'd1);
    checkOutput("sh_done", 64'(dl), 64'd4);
    checkOutput("sh_loaddata", ld, 64'd0);
    checkOutput("sh_mem", mem[2], 64'h88776655ABCD2211);

    applyStimulus(1'b1, 3'b011, 64'h18, 64'hFFFFFFFFFFFFFFFF, dl, wl, wc, ld, mis);
    checkOutput("sd_wr_cycle", 64'(wl), 64'd1);
    checkOutput("sd_done", 64'(dl), 64'd2);
    checkOutput("sd_mem", mem[3], 64'hFFFFFFFFFFFFFFFF);

    applyStimulus(1'b0, 3'b001, 64'h11, '0, dl, wl, wc, ld, mis);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("lh_mis_flag", {63'd0, mis}, 64'd1);
    checkOutput("lh_mis_done", 64'(dl), 64'd1);
    checkOutput("lh_mis_wr", 64'(wc), 64'd0);
    checkOutput("lh_mis_data", ld, 64'd0);
`else
    checkOutput("lh_mis_data", ld, 64'h0000000000002211);
    checkOutput("lh_mis_flag", {63'd0, mis}, 64'd0);
`endif

    // SB aborted by reset in its write cycle.
    Req = 1'b1; IsStore = 1'b1; Funct3 = 3'b000; Addr = 64'h13; StoreData = 64'h5A;
    @(posedge Clk);
    #1 Req = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    checkOutput("abort_memwr", {63'd0, MemWr}, 64'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    checkOutput("abort_raddr", MemRaddress, 64'd0);
    checkOutput("abort_waddr", MemWaddress, 64'd0);
    checkOutput("abort_datain", MemDatain, 64'd0);
    @(negedge Clk);
    checkOutput("abort_ready", {63'd0, Ready}, 64'd1);
    sawDone = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      if (Done) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", {63'd0, sawDone}, 64'd0);
    checkOutput("abort_mem", mem[2], 64'h88776655ABCD2211);

    // Randomized traffic with occasional resets; inputs change every cycle.
    for (int c = 0; c < 2000; c++) begin
      @(posedge Clk);
      #1;
      Reset = ($urandom_range(0, 99) == 0);
      Req = ($urandom_range(0, 3) != 0);
      IsStore = 1'($urandom_range(0, 1));
      Funct3 = 3'($urandom_range(0, 7));
      Addr = 64'($urandom_range(0, 255));
      StoreData = {$urandom, $urandom};
    end
    @(posedge Clk);
    #1 Reset = 1'b0; Req = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    for (int i = 0; i < 32; i++) checkOutput($sformatf("final_mem%0d", i), mem[i], refMem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
